// File: rtl/fft_pkg.sv
// Shared constants for the FFT datapath: default geometry, derived pipeline depth,
// scheduler state encoding and the butterfly data width.
package fft_pkg;

    localparam int unsigned LOG2_N_DEF       = 6;
    localparam int unsigned READ_LATENCY_DEF = 1;
    localparam int unsigned BFLY_LATENCY_DEF = 3;
    localparam int unsigned PIPE_DEF         = READ_LATENCY_DEF + BFLY_LATENCY_DEF;

    // Samples are Q1.(DATA_W-1) fixed point in both RAM and butterfly.
    localparam int unsigned DATA_W = 16;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 2'd0;
    localparam sched_state_t ST_RUN   = 2'd1;
    localparam sched_state_t ST_DRAIN = 2'd2;
    localparam sched_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/fft_stage_scheduler_if.sv
// Scheduler control bus: start/busy/done handshake plus RAM read, twiddle and write-back addressing.
interface fft_stage_scheduler_if
    import fft_pkg::*;
#(
    parameter int unsigned LOG2_N = LOG2_N_DEF
);

    logic              start;
    logic              busy;
    logic              done;
    logic [LOG2_N-1:0] stage;
    logic              rd_en;
    logic [LOG2_N-1:0] rd_addr_a;
    logic [LOG2_N-1:0] rd_addr_b;
    logic [LOG2_N-2:0] tw_addr;
    logic              wr_en;
    logic [LOG2_N-1:0] wr_addr_a;
    logic [LOG2_N-1:0] wr_addr_b;

    modport master (
        input  start,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  wr_en, wr_addr_a, wr_addr_b
    );

endinterface

// File: rtl/delay.sv
// Fixed-length register delay line without reset; callers qualify the output with their own valid.
module delay #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CYCLES = 1
) (
    input  logic             i_clk,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [CYCLES];

    always_ff @(posedge i_clk) begin
        r_pipe[0] <= i_d;
        for (int i = 1; i < int'(CYCLES); i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[CYCLES-1];

endmodule

// File: rtl/fft_stage_scheduler.sv
// In-place radix-2 DIT FFT scheduler: one butterfly per cycle per stage, a PIPE-cycle drain
// between stages, and write-back addresses delayed to match the butterfly outputs.
module fft_stage_scheduler
    import fft_pkg::*;
#(
    parameter int unsigned LOG2_N       = LOG2_N_DEF,
    parameter int unsigned READ_LATENCY = READ_LATENCY_DEF,
    parameter int unsigned BFLY_LATENCY = BFLY_LATENCY_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fft_stage_scheduler_if.master io_bus
);

    localparam int unsigned PIPE = READ_LATENCY + BFLY_LATENCY;
    localparam int unsigned KW   = LOG2_N - 1;
    localparam int unsigned CW   = $clog2(PIPE + 1);

    localparam logic [KW-1:0]     K_LAST     = '1;
    localparam logic [KW-1:0]     K_ONE      = KW'(1);
    localparam logic [LOG2_N-1:0] S_LAST     = LOG2_N'(LOG2_N - 1);
    localparam logic [LOG2_N-1:0] S_ONE      = LOG2_N'(1);
    localparam logic [CW-1:0]     DRAIN_LOAD = CW'(PIPE);
    localparam logic [CW-1:0]     DRAIN_ONE  = CW'(1);

    sched_state_t      r_state;
    logic [LOG2_N-1:0] r_stage;
    logic [KW-1:0]     r_k;
    logic [CW-1:0]     r_drain;
    logic [PIPE-1:0]   r_vld;

    logic                w_rd_en;
    logic [LOG2_N-1:0]   w_k, w_span, w_g, w_j, w_a, w_b, w_tw_shift;
    logic [LOG2_N-2:0]   w_tw;
    logic [LOG2_N-1:0]   w_rd_a, w_rd_b;
    logic [2*LOG2_N-1:0] w_wr_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
            r_k     <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start) begin
                        r_state <= ST_RUN;
                        r_stage <= '0;
                        r_k     <= '0;
                    end
                end
                ST_RUN: begin
                    r_k <= r_k + K_ONE;
                    if (r_k == K_LAST) begin
                        r_state <= ST_DRAIN;
                        r_drain <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    r_drain <= r_drain - DRAIN_ONE;
                    if (r_drain == DRAIN_ONE) begin
                        if (r_stage == S_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                            r_stage <= r_stage + S_ONE;
                            r_k     <= '0;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Butterfly k of stage s pairs a = g*2*span + j with a + span.
    assign w_k        = {1'b0, r_k};
    assign w_span     = S_ONE << r_stage;
    assign w_g        = w_k >> r_stage;
    assign w_j        = w_k & (w_span - S_ONE);
    assign w_a        = ((w_g << r_stage) << 1) + w_j;
    assign w_b        = w_a + w_span;
    assign w_tw_shift = S_LAST - r_stage;
    assign w_tw       = w_j[LOG2_N-2:0] << w_tw_shift;

    assign w_rd_en = (r_state == ST_RUN);
    assign w_rd_a  = w_rd_en ? w_a : '0;
    assign w_rd_b  = w_rd_en ? w_b : '0;

    // Valid bit kept apart from the unreset address delay so reset drops wr_en immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd_en;
            for (int i = 1; i < int'(PIPE); i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    delay #(
        .WIDTH  (2 * LOG2_N),
        .CYCLES (PIPE)
    ) u_addr_dly (
        .i_clk (i_clk),
        .i_d   ({w_rd_a, w_rd_b}),
        .o_q   (w_wr_addr)
    );

    assign io_bus.busy      = (r_state != ST_IDLE);
    assign io_bus.done      = (r_state == ST_DONE);
    assign io_bus.stage     = r_stage;
    assign io_bus.rd_en     = w_rd_en;
    assign io_bus.rd_addr_a = w_rd_a;
    assign io_bus.rd_addr_b = w_rd_b;
    assign io_bus.tw_addr   = w_rd_en ? w_tw : '0;
    assign io_bus.wr_en     = r_vld[PIPE-1];
    assign io_bus.wr_addr_a = r_vld[PIPE-1] ? w_wr_addr[2*LOG2_N-1:LOG2_N] : '0;
    assign io_bus.wr_addr_b = r_vld[PIPE-1] ? w_wr_addr[LOG2_N-1:0] : '0;

endmodule
